// File: rtl/dg0045_rom_server_if.sv
// Fetch and load bus between the DG0045 core side (master) and its program-memory server (slave).
// Load handshake: ld_valid/ld_addr/ld_data stay stable until a cycle with ld_valid && ld_ready; that cycle's write is taken and ld_ready never depends on ld_valid.
interface dg0045_rom_server_if;
  logic [4:0] pc_hl;
  logic       pc_mux;
  logic [7:0] rom_data;
  logic       addr_valid;
  logic       addr_changed;
  logic [9:0] cur_addr;
  logic       ld_valid;
  logic       ld_ready;
  logic [9:0] ld_addr;
  logic [7:0] ld_data;

  modport master (
    output pc_hl,
    output ld_valid,
    output ld_addr,
    output ld_data,
    input  pc_mux,
    input  rom_data,
    input  addr_valid,
    input  addr_changed,
    input  cur_addr,
    input  ld_ready
  );

  modport slave (
    input  pc_hl,
    input  ld_valid,
    input  ld_addr,
    input  ld_data,
    output pc_mux,
    output rom_data,
    output addr_valid,
    output addr_changed,
    output cur_addr,
    output ld_ready
  );
endinterface

// File: rtl/dg0045_rom_server.sv
// Program-memory responder for the DG0045 fetch port: demultiplexes pc_hl, looks up a 1K x 8 store, serves rom_data.
// Optional macro DG0045_ROM_SYNC_IN_EN adds a 2-flop pc_hl synchronizer and stretches each SET phase by 2 cycles.
module dg0045_rom_server #(
  parameter int         MUX_HOLD = 2,
  parameter logic [7:0] RST_DATA = 8'h00
) (
  input  logic                      clk,
  input  logic                      rst,
  dg0045_rom_server_if.slave        bus,
  output logic [2:0]                dbg_state
);

  typedef enum logic [2:0] {
    SET_HI = 3'd0,
    CAP_HI = 3'd1,
    SET_LO = 3'd2,
    CAP_LO = 3'd3,
    LOOKUP = 3'd4
  } state_t;

`ifdef DG0045_ROM_SYNC_IN_EN
  localparam int SET_CYCLES = MUX_HOLD + 2;
`else
  localparam int SET_CYCLES = MUX_HOLD;
`endif
  localparam logic [4:0] SET_LAST = 5'(SET_CYCLES - 1);

  state_t     state;
  state_t     state_nxt;
  logic [4:0] hold_cnt;
  logic [4:0] hold_nxt;
  logic       mux_sel;
  logic       cap_hi;
  logic       cap_lo;
  logic       lookup;
  logic       ld_ok;

  logic [4:0] pc_sample;
  logic [4:0] hi_reg;
  logic [4:0] lo_reg;
  logic [9:0] fetch_addr;
  logic [7:0] rom_q;
  logic [9:0] cur_q;
  logic       valid_q;
  logic       changed_q;
  logic       wr_en;

  logic [7:0] mem [0:1023];

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= SET_HI;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    mux_sel   = 1'b1;
    cap_hi    = 1'b0;
    cap_lo    = 1'b0;
    lookup    = 1'b0;
    ld_ok     = 1'b1;
    case (state)
      SET_HI: begin
        if (hold_cnt == SET_LAST) begin
          hold_nxt  = '0;
          state_nxt = CAP_HI;
        end else begin
          hold_nxt = hold_cnt + 5'd1;
        end
      end
      CAP_HI: begin
        cap_hi    = 1'b1;
        state_nxt = SET_LO;
      end
      SET_LO: begin
        mux_sel = 1'b0;
        if (hold_cnt == SET_LAST) begin
          hold_nxt  = '0;
          state_nxt = CAP_LO;
        end else begin
          hold_nxt = hold_cnt + 5'd1;
        end
      end
      CAP_LO: begin
        mux_sel   = 1'b0;
        cap_lo    = 1'b1;
        state_nxt = LOOKUP;
      end
      LOOKUP: begin
        // The single store port belongs to the read this cycle.
        mux_sel   = 1'b0;
        lookup    = 1'b1;
        ld_ok     = 1'b0;
        state_nxt = SET_HI;
      end
      default: begin
        hold_nxt  = '0;
        state_nxt = SET_HI;
      end
    endcase
  end

  // ---------------------------------------------------------------- input sampling
`ifdef DG0045_ROM_SYNC_IN_EN
  logic [4:0] sync_q1;
  logic [4:0] sync_q2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= bus.pc_hl;
      sync_q2 <= sync_q1;
    end
  end

  assign pc_sample = sync_q2;
`else
  assign pc_sample = bus.pc_hl;
`endif

  // ---------------------------------------------------------------- capture and lookup
  assign fetch_addr = {hi_reg, lo_reg};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_reg    <= '0;
      lo_reg    <= '0;
      rom_q     <= RST_DATA;
      cur_q     <= '0;
      valid_q   <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      valid_q   <= lookup;
      changed_q <= lookup && (fetch_addr != cur_q);
      if (cap_hi) begin
        hi_reg <= pc_sample;
      end
      if (cap_lo) begin
        lo_reg <= pc_sample;
      end
      if (lookup) begin
        rom_q <= mem[fetch_addr];
        cur_q <= fetch_addr;
      end
    end
  end

  // ---------------------------------------------------------------- load port
  // Store contents survive reset; only the handshake is gated by rst.
  assign wr_en = bus.ld_valid && bus.ld_ready;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[bus.ld_addr] <= bus.ld_data;
    end
  end

  // ---------------------------------------------------------------- outputs
  assign bus.pc_mux       = mux_sel;
  assign bus.ld_ready     = ld_ok && !rst;
  assign bus.rom_data     = rom_q;
  assign bus.cur_addr     = cur_q;
  assign bus.addr_valid   = valid_q;
  assign bus.addr_changed = changed_q;
  assign dbg_state        = state;

endmodule

// File: tb/tb_dg0045_rom_server.sv
// Randomized bench for dg0045_rom_server: frame-schedule reference model, load queue and expected-lookup scoreboard.
module tb_dg0045_rom_server;

  localparam int         MUX_HOLD = 2;
  localparam logic [7:0] RST_DATA = 8'hE7;
`ifdef DG0045_ROM_SYNC_IN_EN
  localparam int SET = MUX_HOLD + 2;
`else
  localparam int SET = MUX_HOLD;
`endif
  localparam int P = 2 * SET + 3;
  localparam int W = 20;

  // ---------------------------------------------------------------- clock / reset / DUT
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] dbg_state;

  dg0045_rom_server_if bus ();

  dg0045_rom_server #(
    .MUX_HOLD (MUX_HOLD),
    .RST_DATA (RST_DATA)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------- reference model state
  logic [7:0]   ref_mem [1024];
  bit           ref_known [1024];
  logic [W-1:0] exp_q[$];          // {known, changed, addr[9:0], data[7:0]}
  logic [17:0]  load_q[$];         // {addr[9:0], data[7:0]}
  logic [9:0]   tgt_q[$];
  int           cyc;               // 1 = first cycle after reset release
  logic [9:0]   frame_tgt;
  logic [9:0]   prev_tgt;
  logic [9:0]   prev_addr;
  logic [9:0]   held_addr;
  logic [7:0]   held_data;
  bit           held_known;
  bit           glitch;
  bit           presenting;
  bit           ld_gaps;
  int           n_checks;
  int           n_errors;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic reset_model();
    cyc        = 1;
    prev_addr  = '0;
    held_addr  = '0;
    held_data  = RST_DATA;
    held_known = 1'b1;
    exp_q.delete();
  endtask

  task automatic check_in_reset();
    check("rst_pc_mux",       32'(bus.pc_mux),       1);
    check("rst_rom_data",     32'(bus.rom_data),     32'(RST_DATA));
    check("rst_addr_valid",   32'(bus.addr_valid),   0);
    check("rst_addr_changed", 32'(bus.addr_changed), 0);
    check("rst_cur_addr",     32'(bus.cur_addr),     0);
    check("rst_ld_ready",     32'(bus.ld_ready),     0);
  endtask

  // One clock cycle: entered at a negedge, checks outputs, drives inputs, advances the model.
  task automatic step();
    int           pos;
    bit           exp_valid;
    bit           exp_ready;
    logic [W-1:0] e;
    logic [9:0]   a;
    logic [4:0]   drv;
    pos = (cyc - 1) % P;
    if (pos == 0) begin
      if (tgt_q.size() > 0) frame_tgt = tgt_q.pop_front();
      else if ($urandom_range(0, 3) == 0) frame_tgt = prev_tgt;
      else frame_tgt = 10'($urandom_range(0, 1023));
      prev_tgt = frame_tgt;
      glitch   = ($urandom_range(0, 1) == 1);
    end
    exp_valid = (pos == 0) && (cyc > P);
    exp_ready = (pos != P - 1);

    check("pc_mux",     32'(bus.pc_mux),     32'(pos <= SET));
    check("ld_ready",   32'(bus.ld_ready),   32'(exp_ready));
    check("addr_valid", 32'(bus.addr_valid), 32'(exp_valid));
    if (exp_valid) begin
      if (exp_q.size() > 0) begin
        e          = exp_q.pop_front();
        held_known = e[19];
        held_addr  = e[17:8];
        held_data  = e[7:0];
        check("addr_changed", 32'(bus.addr_changed), 32'(e[18]));
      end else begin
        check("exp_q_size", 32'(exp_q.size()), 1);
      end
    end else begin
      check("addr_changed_idle", 32'(bus.addr_changed), 0);
    end
    check("cur_addr", 32'(bus.cur_addr), 32'(held_addr));
    if (held_known) check("rom_data", 32'(bus.rom_data), 32'(held_data));

    // Core side: upper half while pc_mux is high in the schedule, lower half otherwise.
    drv = (pos <= SET) ? frame_tgt[9:5] : frame_tgt[4:0];
`ifdef DG0045_ROM_SYNC_IN_EN
    if (glitch && (pos == SET - 1 || pos == SET || pos == 2 * SET || pos == 2 * SET + 1))
      drv = 5'($urandom_range(0, 31));
`endif
    bus.pc_hl = drv;

    if (!presenting && load_q.size() > 0 && !(ld_gaps && $urandom_range(0, 2) == 0))
      presenting = 1'b1;
    bus.ld_valid = presenting;
    if (presenting) begin
      bus.ld_addr = load_q[0][17:8];
      bus.ld_data = load_q[0][7:0];
    end else begin
      bus.ld_addr = 10'($urandom_range(0, 1023));
      bus.ld_data = 8'($urandom);
    end

    @(posedge clk);
    if (pos == P - 1) begin
      a = frame_tgt;
      exp_q.push_back({ref_known[a], a != prev_addr, a, ref_mem[a]});
      prev_addr = a;
    end else if (presenting) begin
      ref_mem[load_q[0][17:8]]   = load_q[0][7:0];
      ref_known[load_q[0][17:8]] = 1'b1;
      void'(load_q.pop_front());
      presenting = 1'b0;
    end
    cyc++;
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------- stimulus and report
  initial begin
    n_checks     = 0;
    n_errors     = 0;
    presenting   = 1'b0;
    ld_gaps      = 1'b0;
    prev_tgt     = '0;
    frame_tgt    = '0;
    cyc          = 0;
    bus.pc_hl    = '0;
    bus.ld_valid = 1'b0;
    bus.ld_addr  = '0;
    bus.ld_data  = '0;
    rst          = 1'b1;
    repeat (3) @(negedge clk);
    check_in_reset();

    // Idle frames on address 0; a byte is loaded at 0 so the first lookup is checkable.
    load_q.push_back({10'h000, 8'($urandom)});
    tgt_q.push_back(10'h000);
    tgt_q.push_back(10'h000);
    rst = 1'b0;
    reset_model();
    #1;
    repeat (2 * P) step();

    // Fill the whole store with back-to-back writes.
    for (int i = 0; i < 1024; i++) load_q.push_back({10'(i), 8'($urandom)});
    for (int k = 0; k < 1400 && load_q.size() > 0; k++) step();
    check("fill_drain", 32'(load_q.size()), 0);

    // 0x3C5 scenario: load A5, two frames on it, then 5A offered during LOOKUP.
    while ((cyc - 1) % P != 0) step();
    load_q.push_back({10'h3C5, 8'hA5});
    tgt_q.push_back(10'h3C5);
    tgt_q.push_back(10'h3C5);
    repeat (2 * P - 1) step();
    load_q.push_back({10'h3C5, 8'h5A});
    tgt_q.push_back(10'h3C5);
    repeat (2 * P + 1) step();

    // Random frames with gapped loads, some aimed at the address being fetched.
    ld_gaps = 1'b1;
    for (int k = 0; k < 60 * P; k++) begin
      if (load_q.size() < 3 && $urandom_range(0, 3) == 0)
        load_q.push_back({($urandom_range(0, 1) == 1) ? frame_tgt : 10'($urandom_range(0, 1023)),
                          8'($urandom)});
      step();
    end

    // Reset inside SET_LO after the upper half was captured.
    while ((cyc - 1) % P != SET + 2) step();
    rst = 1'b1;
    #1;
    check_in_reset();
    repeat (2) @(negedge clk);
    check_in_reset();
    rst = 1'b0;
    reset_model();
    #1;
    for (int k = 0; k < 30 * P; k++) begin
      if (load_q.size() < 3 && $urandom_range(0, 3) == 0)
        load_q.push_back({10'($urandom_range(0, 1023)), 8'($urandom)});
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dg0045_rom_server.md
Name: dg0045_rom_server

Overview:
- Program-memory responder on the far side of the DG0045 core's fetch interface.
- Drives the PC_MUX select and captures the two 5-bit halves of the multiplexed program counter (PC_HL). It rebuilds the 10-bit fetch address, looks it up in an internal 1K x 8 program store and presents the instruction byte on the core's mainROM input.
- A byte-wide load port fills the store before or during execution.

Parameters:
- MUX_HOLD, 2, cycles each pc_mux phase settles before capture (1..15)
- RST_DATA, 8'h00, rom_data value after reset

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- pc_hl  in  5  multiplexed PC from core: {PU,PL[5]} when pc_mux=1, PL[4:0] when pc_mux=0
- pc_mux  out  1  half select driven to core
- rom_data  out  8  instruction byte to core mainROM
- addr_valid  out  1  one-cycle pulse: rom_data/cur_addr just updated
- addr_changed  out  1  one-cycle pulse with addr_valid when cur_addr differs from previous frame
- cur_addr  out  10  last assembled fetch address
- ld_valid  in  1  load request
- ld_ready  out  1  load accepted this cycle when ld_valid=1
- ld_addr  in  10  load address
- ld_data  in  8  load byte

Behaviour:
- Interface: one clock; reset is asynchronous and active-high, ports clk and rst.
- Reset values:
  - pc_mux=1
  - rom_data=RST_DATA
  - addr_valid=0, addr_changed=0
  - cur_addr=0
  - ld_ready=0 while rst high
  - FSM=SET_HI, hold counter=0
- Store contents are not reset.
- FSM runs continuously, frame period = 2*MUX_HOLD+3 cycles (7 at default):
  - SET_HI: pc_mux=1 for MUX_HOLD cycles, then CAP_HI.
  - CAP_HI: pc_mux=1; hi_reg<=pc_hl at end of cycle; then SET_LO.
  - SET_LO: pc_mux=0 for MUX_HOLD cycles, then CAP_LO.
  - CAP_LO: pc_mux=0; lo_reg<=pc_hl; then LOOKUP.
  - LOOKUP: pc_mux=0; rom_data<=mem[{hi_reg,lo_reg}]; cur_addr<={hi_reg,lo_reg}; then SET_HI.
- Output timing:
  - addr_valid is high exactly in the cycle after LOOKUP, the first cycle the new rom_data/cur_addr is visible.
  - addr_changed is high in that same cycle iff new cur_addr != previous cur_addr. The first frame after reset compares against 0.
  - rom_data holds its value between lookups; no glitching.
- Address assembly: addr[9:5]=hi_reg, addr[4:0]=lo_reg; no arithmetic or wrap, pure concatenation.
- Load port:
  - ld_ready=1 in every state except LOOKUP; the store is single-port and a read takes priority.
  - Write occurs on a cycle with ld_valid & ld_ready: mem[ld_addr]<=ld_data.
  - If ld_valid is asserted in LOOKUP, ld_ready=0. The requester holds ld_valid, ld_addr and ld_data until accepted.
  - A write to the address currently in cur_addr does not change rom_data until the next LOOKUP.
  - Back-to-back writes are allowed, one per cycle.
- Reset mid-frame: FSM returns to SET_HI immediately and pc_mux goes to 1. Partial hi/lo captures are discarded and no addr_valid is produced. A load accepted in the same cycle rst rises is dropped.
- MUX_HOLD=0 is illegal; the implementation may assert at elaboration.

Optional Feature:
- Macro: DG0045_ROM_SYNC_IN_EN.
- Defined:
  - pc_hl passes through a 2-flop synchronizer before capture.
  - CAP_HI/CAP_LO sample the synchronizer output.
  - Each SET phase lasts MUX_HOLD+2 cycles, so frame period = 2*MUX_HOLD+7.
  - Required when the core runs from an unrelated clock.
- Undefined: pc_hl is sampled directly and frame timing is as above.

Test Plan:
- Reset then idle, MUX_HOLD=2, pc_hl=0 → pc_mux sequence 1,1,1,0,0,0,0 repeating. First addr_valid in cycle 8 after rst deassert, rom_data=mem[0], addr_changed=0.
- Load 0xA5 at 0x3C5; drive pc_hl=0x1E while pc_mux=1 and 0x05 while pc_mux=0 → next frame cur_addr=0x3C5, rom_data=0xA5, addr_valid=1 and addr_changed=1 for one cycle.
- Same address held for a second frame → addr_valid=1, addr_changed=0, rom_data stays 0xA5.
- ld_valid asserted during LOOKUP with ld_addr=0x3C5, ld_data=0x5A → ld_ready=0 that cycle, write accepted next cycle. Current rom_data stays 0xA5; following frame shows 0x5A.
- rst pulsed during SET_LO after hi was captured → pc_mux=1 immediately, rom_data=RST_DATA, no addr_valid until a full new frame completes.
- With DG0045_ROM_SYNC_IN_EN, repeat the 0x3C5 scenario → same data. Frame period 11 cycles; pc_hl changed 1 cycle before CAP is not captured.
